// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchronizer plus debounce FSM for a raw push-button;
//               emits a clean level, single-cycle rise/fall pulses and a
//               5-bit press counter.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key,
  output logic       clean,
  output logic       rise,
  output logic       fall,
  output logic [4:0] presses
);

  localparam int c_cnt_w = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HIGH   = 2'd2,
    ST_CHK_LO = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_s1;
  logic                 r_s2;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 r_clean;
  logic                 r_rise;
  logic                 r_fall;
  logic                 w_clean_nxt;
  logic                 w_rise_nxt;
  logic                 w_fall_nxt;
  logic [4:0]           r_presses;
  logic [4:0]           w_presses_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_state   <= ST_LOW;
      r_cnt     <= '0;
      r_clean   <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_presses <= 5'd0;
    end else begin
      r_s1      <= key;
      r_s2      <= r_s1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clean   <= w_clean_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_presses <= w_presses_nxt;
    end
  end

  // A bounce in either check state drops back to the prior stable level;
  // the counter is reloaded on the next opposite sample, so no credit carries.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_clean_nxt   = r_clean;
    w_rise_nxt    = 1'b0;
    w_fall_nxt    = 1'b0;
    w_presses_nxt = r_presses;
    case (r_state)
      ST_LOW: begin
        if (r_s2) begin
          w_state_nxt = ST_CHK_HI;
          w_cnt_nxt   = c_cnt_one;
        end
      end
      ST_CHK_HI: begin
        if (!r_s2) begin
          w_state_nxt = ST_LOW;
        end else if (r_cnt == c_cnt_max) begin
          w_state_nxt   = ST_HIGH;
          w_clean_nxt   = 1'b1;
          w_rise_nxt    = 1'b1;
          w_presses_nxt = r_presses + 5'd1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      ST_HIGH: begin
        if (!r_s2) begin
          w_state_nxt = ST_CHK_LO;
          w_cnt_nxt   = c_cnt_one;
        end
      end
      ST_CHK_LO: begin
        if (r_s2) begin
          w_state_nxt = ST_HIGH;
        end else if (r_cnt == c_cnt_max) begin
          w_state_nxt = ST_LOW;
          w_clean_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
      end
    endcase
  end

  assign clean   = r_clean;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign presses = r_presses;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce
// Description : Directed bench for key_debounce with an event scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

  localparam int D = 4;

  typedef struct {
    int         cyc;
    logic       rise;
    logic       fall;
    logic [4:0] presses;
  } evt_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key   = 1'b0;
  logic       clean;
  logic       rise;
  logic       fall;
  logic [4:0] presses;

  evt_t       sb[$];
  int         cyc       = 0;
  int         pass_cnt  = 0;
  int         fail_cnt  = 0;
  int         total_cnt = 0;
  logic       exp_clean = 1'b0;
  logic [4:0] exp_pres  = 5'd0;
  logic [4:0] nxt_pres  = 5'd0;

  key_debounce #(.DEBOUNCE(D)) dut (
    .clock   (clock),
    .reset   (reset),
    .key     (key),
    .clean   (clean),
    .rise    (rise),
    .fall    (fall),
    .presses (presses)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock edge, then compare outputs against the scoreboard.
  task automatic tick();
    evt_t e;
    @(posedge clock);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("rise_evt", 8'(rise), 8'(e.rise));
      check("fall_evt", 8'(fall), 8'(e.fall));
      exp_clean = e.rise;
      exp_pres  = e.presses;
    end else begin
      check("no_rise", 8'(rise), 8'd0);
      check("no_fall", 8'(fall), 8'd0);
    end
    check("clean", 8'(clean), 8'(exp_clean));
    check("presses", 8'(presses), 8'(exp_pres));
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    sb.delete();
    exp_clean = 1'b0;
    exp_pres  = 5'd0;
    nxt_pres  = 5'd0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Drive key to k for n edges; when ev is set, the run is long enough to be
  // accepted and the event lands D+2 edges after the first new sample.
  task automatic hold(input logic k, input int n, input logic ev);
    key = k;
    if (ev) begin
      if (k) begin
        nxt_pres = nxt_pres + 5'd1;
        sb.push_back('{cyc + 1 + D + 2, 1'b1, 1'b0, nxt_pres});
      end else begin
        sb.push_back('{cyc + 1 + D + 2, 1'b0, 1'b1, nxt_pres});
      end
    end
    repeat (n) tick();
  endtask

  initial begin
    // reset and idle
    do_reset(2);
    hold(1'b0, 20, 1'b0);

    // clean press and release
    hold(1'b1, 20, 1'b1);
    hold(1'b0, 20, 1'b1);

    // glitches of exactly D samples are rejected, D+1 is accepted
    hold(1'b1, 4, 1'b0);
    hold(1'b0, 3, 1'b0);
    hold(1'b1, 4, 1'b0);
    hold(1'b0, 10, 1'b0);
    hold(1'b1, 5, 1'b1);
    hold(1'b0, 20, 1'b1);

    // bounce on release
    hold(1'b1, 20, 1'b1);
    hold(1'b0, 2, 1'b0);
    hold(1'b1, 1, 1'b0);
    hold(1'b0, 20, 1'b1);

    // counter wrap over 33 presses
    do_reset(1);
    hold(1'b0, 5, 1'b0);
    for (int i = 0; i < 33; i++) begin
      hold(1'b1, 6, 1'b1);
      hold(1'b0, 6, 1'b1);
    end

    // reset while qualifying, then re-qualify with key held high
    hold(1'b1, 3, 1'b0);
    do_reset(1);
    hold(1'b1, 12, 1'b1);

    // reset while HIGH with key held high
    do_reset(1);
    hold(1'b1, 12, 1'b1);
    hold(1'b0, 12, 1'b1);

    // reset lands on the accepting edge
    hold(1'b1, 6, 1'b1);
    do_reset(1);
    hold(1'b1, 12, 1'b1);
    hold(1'b0, 12, 1'b1);

    check("sb_empty", 8'(sb.size()), 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
